// File: rtl/dac_playback_ctrl.sv
// Waveform playback sequencer for a 10-bit interleaved I/Q DAC.
// Powers the DAC up, waits for it to settle, then streams samples from a
// BRAM with one cycle of read latency onto S_Data. It generates S_DCLKIO at a
// programmable sample period. Playback is single-shot or looped.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ST_OFF | DAC powered down, S_Data at midscale, waiting for Start
// ST_WAKE| DAC powered up, settling; last cycle prefetches sample 0
// ST_RUN | streaming one sample per period of P clocks
module dac_playback_ctrl #(
  parameter int DAC_WIDTH   = 10,
  parameter int ADDR_WIDTH  = 14,
  parameter int DIV_WIDTH   = 16,
  parameter int WAKE_CYCLES = 64,
  parameter int IDLE_CODE   = 512
) (
  input  logic                  SPLB_Clk,
  input  logic                  SPLB_Rst_n,
  input  logic                  Ctrl_Start,
  input  logic                  Ctrl_Stop,
  input  logic                  Ctrl_Loop,
  input  logic [ADDR_WIDTH-1:0] Ctrl_Length,
  input  logic [DIV_WIDTH-1:0]  Ctrl_Div,
  input  logic [1:0]            Ctrl_IQEn,
  output logic                  Mem_Rd,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  input  logic [DAC_WIDTH-1:0]  Mem_Data,
  output logic [DAC_WIDTH-1:0]  S_Data,
  output logic                  S_DCLKIO,
  output logic                  S_PWRDN,
  output logic                  S_OpEnI,
  output logic                  S_OpEnQ,
  output logic                  Sts_Busy,
  output logic                  Sts_Done,
  output logic [ADDR_WIDTH-1:0] Sts_Idx
);

  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_RUN} state_t;

  state_t                 state, state_n;
  logic [DIV_WIDTH-1:0]   phase, phase_n;
  logic [WAKE_W-1:0]      wake_cnt, wake_n;
  logic                   stop_req, stop_req_n;
  logic                   latch;
  logic [ADDR_WIDTH-1:0]  len;
  logic                   loop_en;
  logic [1:0]             iq_en;
  logic [DIV_WIDTH-1:0]   per_m1;
  logic [DIV_WIDTH-1:0]   half;

  logic                   rd_n;
  logic [ADDR_WIDTH-1:0]  addr_n;
  logic [DAC_WIDTH-1:0]   data_n;
  logic [ADDR_WIDTH-1:0]  idx_n;
  logic                   done_n;

  // Period minus one is clamped to 3 so the DCLK high phase always leaves
  // at least one clock of setup after S_Data changes in phase 1.
  logic [DIV_WIDTH-1:0]   div_clamp;
  logic [DIV_WIDTH:0]     per_full;
  logic [ADDR_WIDTH-1:0]  nxt_idx;
  logic                   more;
  logic                   stop_any;

  assign div_clamp = (Ctrl_Div < DIV_WIDTH'(3)) ? DIV_WIDTH'(3) : Ctrl_Div;
  assign per_full  = {1'b0, div_clamp} + {{DIV_WIDTH{1'b0}}, 1'b1};
  assign nxt_idx   = (Mem_Addr == len) ? '0 : Mem_Addr + 1'b1;
  assign more      = (Mem_Addr != len) || loop_en;
  assign stop_any  = stop_req || Ctrl_Stop;

  // State register, counters and configuration latched at Start
  always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
    if (!SPLB_Rst_n) begin
      state    <= ST_OFF;
      phase    <= '0;
      wake_cnt <= '0;
      stop_req <= 1'b0;
      len      <= '0;
      loop_en  <= 1'b0;
      iq_en    <= 2'b00;
      per_m1   <= DIV_WIDTH'(3);
      half     <= DIV_WIDTH'(2);
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      wake_cnt <= wake_n;
      stop_req <= stop_req_n;
      if (latch) begin
        len     <= Ctrl_Length;
        loop_en <= Ctrl_Loop;
        iq_en   <= Ctrl_IQEn;
        per_m1  <= div_clamp;
        half    <= per_full[DIV_WIDTH:1];
      end
    end
  end

  // Next state plus the next values of every registered output
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    wake_n     = wake_cnt;
    stop_req_n = stop_req;
    latch      = 1'b0;
    rd_n       = 1'b0;
    addr_n     = Mem_Addr;
    data_n     = S_Data;
    idx_n      = Sts_Idx;
    done_n     = 1'b0;
    case (state)
      ST_OFF: begin
        if (Ctrl_Start && !Ctrl_Stop) begin
          state_n    = ST_WAKE;
          wake_n     = WAKE_W'(WAKE_CYCLES - 1);
          stop_req_n = 1'b0;
          latch      = 1'b1;
        end
      end
      ST_WAKE: begin
        if (Ctrl_Stop) begin
          state_n = ST_OFF;
          done_n  = 1'b1;
        end else if (wake_cnt == '0) begin
          state_n = ST_RUN;
          phase_n = '0;
        end else begin
          wake_n = wake_cnt - 1'b1;
          if (wake_cnt == WAKE_W'(1)) begin
            rd_n   = 1'b1;
            addr_n = '0;
          end
        end
      end
      ST_RUN: begin
        if (Ctrl_Stop) stop_req_n = 1'b1;
        if (phase == '0) begin
          data_n = Mem_Data;
          idx_n  = Mem_Addr;
        end
        // The read strobe is registered, so the decision is made one phase early.
        if (phase == per_m1 - 1'b1 && more && !stop_any) begin
          rd_n   = 1'b1;
          addr_n = nxt_idx;
        end
        if (phase == per_m1) begin
          if (Mem_Rd && !stop_any) begin
            phase_n = '0;
          end else begin
            state_n = ST_OFF;
            done_n  = 1'b1;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = ST_OFF;
    endcase
    if (state_n == ST_OFF) data_n = DAC_WIDTH'(IDLE_CODE);
  end

  // Output registers, all derived from the next state
  always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
    if (!SPLB_Rst_n) begin
      Mem_Rd   <= 1'b0;
      Mem_Addr <= '0;
      S_Data   <= DAC_WIDTH'(IDLE_CODE);
      S_DCLKIO <= 1'b0;
      S_PWRDN  <= 1'b1;
      S_OpEnI  <= 1'b0;
      S_OpEnQ  <= 1'b0;
      Sts_Busy <= 1'b0;
      Sts_Done <= 1'b0;
      Sts_Idx  <= '0;
    end else begin
      Mem_Rd   <= rd_n;
      Mem_Addr <= addr_n;
      S_Data   <= data_n;
      S_DCLKIO <= (state_n == ST_RUN) && (phase_n >= half);
      S_PWRDN  <= (state_n == ST_OFF);
      S_OpEnI  <= (state_n == ST_RUN) && (latch ? Ctrl_IQEn[1] : iq_en[1]);
      S_OpEnQ  <= (state_n == ST_RUN) && (latch ? Ctrl_IQEn[0] : iq_en[0]);
      Sts_Busy <= (state_n != ST_OFF);
      Sts_Done <= done_n;
      Sts_Idx  <= idx_n;
    end
  end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl with a small BRAM model and an
// edge monitor that logs DCLK rises, read strobes and Done pulses.
module tb_dac_playback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [13:0] length = '0;
  logic [15:0] div = '0;
  logic [1:0]  iq = 2'b00;
  logic        mem_rd;
  logic [13:0] mem_addr, sts_idx;
  logic [9:0]  mem_data = '0, s_data;
  logic        dclk, pwrdn, open_i, open_q, busy, done;

  logic [9:0]  mem [0:15];
  int          cyc = 0;
  int          total = 0, bad = 0;
  int          done_cnt = 0;
  logic        dclk_prev = 1'b0;
  int          rise_data[$], rise_cyc[$], rise_iq[$], rise_idx[$], rd_addr[$];
  int          cyc_set;

  dac_playback_ctrl #(.WAKE_CYCLES(4)) dut (
    .SPLB_Clk(clk), .SPLB_Rst_n(rst_n),
    .Ctrl_Start(start), .Ctrl_Stop(stop), .Ctrl_Loop(loop_en),
    .Ctrl_Length(length), .Ctrl_Div(div), .Ctrl_IQEn(iq),
    .Mem_Rd(mem_rd), .Mem_Addr(mem_addr), .Mem_Data(mem_data),
    .S_Data(s_data), .S_DCLKIO(dclk), .S_PWRDN(pwrdn),
    .S_OpEnI(open_i), .S_OpEnQ(open_q),
    .Sts_Busy(busy), .Sts_Done(done), .Sts_Idx(sts_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (mem_rd) mem_data <= mem[mem_addr[3:0]];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (dclk && !dclk_prev) begin
        rise_data.push_back(int'(s_data));
        rise_cyc.push_back(cyc);
        rise_iq.push_back(int'({open_i, open_q}));
        rise_idx.push_back(int'(sts_idx));
      end
      if (mem_rd) rd_addr.push_back(int'(mem_addr));
      if (done) done_cnt++;
    end
    dclk_prev = dclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rise_data.delete(); rise_cyc.delete(); rise_iq.delete();
    rise_idx.delete(); rd_addr.delete(); done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc_set = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    mem[0] = 10'h001; mem[1] = 10'h3FF; mem[2] = 10'h155; mem[3] = 10'h2AA;
    for (int i = 4; i < 16; i++) mem[i] = 10'(i * 7);

    // reset values
    repeat (3) @(negedge clk);
    check("rst_sdata", 32'(s_data), 32'h200);
    check("rst_pwrdn", 32'(pwrdn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memrd", 32'(mem_rd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single pass of four samples, P=4
    clear_log();
    length = 14'd3; div = 16'd3; loop_en = 1'b0; iq = 2'b11;
    pulse_start();
    check("t2_pwrdn_low", 32'(pwrdn), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    wait_done("t2", 100);
    check("t2_rises", 32'(rise_data.size()), 32'd4);
    check("t2_first_rise_cyc", 32'(rise_cyc[0]), 32'(cyc_set + 7));
    check("t2_d0", 32'(rise_data[0]), 32'h001);
    check("t2_d1", 32'(rise_data[1]), 32'h3FF);
    check("t2_d2", 32'(rise_data[2]), 32'h155);
    check("t2_d3", 32'(rise_data[3]), 32'h2AA);
    for (int i = 1; i < 4; i++) begin
      check("t2_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd4);
      check("t2_idx", 32'(rise_idx[i]), 32'(i));
    end
    check("t2_iq", 32'(rise_iq[0]), 32'd3);
    check("t2_reads", 32'(rd_addr.size()), 32'd4);
    check("t2_done_count", 32'(done_cnt), 32'd1);
    check("t2_sdata_idle", 32'(s_data), 32'h200);
    check("t2_pwrdn_off", 32'(pwrdn), 32'd1);

    // looped two-sample playback, P=6
    clear_log();
    length = 14'd1; div = 16'd5; loop_en = 1'b1; iq = 2'b10;
    pulse_start();
    repeat (60) @(negedge clk);
    check("t3_no_done", 32'(done_cnt), 32'd0);
    check("t3_rises_enough", 32'(rise_data.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("t3_data", 32'(rise_data[i]), (i % 2 == 0) ? 32'h001 : 32'h3FF);
      check("t3_addr", 32'(rd_addr[i]), 32'(i % 2));
      if (i > 0) check("t3_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd6);
    end
    check("t3_iq", 32'(rise_iq[0]), 32'd2);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_done("t3", 40);

    // stop during phase 1 of sample 2
    clear_log();
    length = 14'd7; div = 16'd3; loop_en = 1'b0; iq = 2'b01;
    pulse_start();
    repeat (13) @(negedge clk);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_done("t4", 40);
    check("t4_rises", 32'(rise_data.size()), 32'd3);
    check("t4_d2", 32'(rise_data[2]), 32'h155);
    check("t4_reads", 32'(rd_addr.size()), 32'd3);
    check("t4_last_addr", 32'(rd_addr[rd_addr.size()-1]), 32'd2);
    check("t4_done_count", 32'(done_cnt), 32'd1);

    // Div=0 clamps to the 4-clock period; a Start mid-run is ignored
    clear_log();
    length = 14'd1; div = 16'd0; loop_en = 1'b0;
    pulse_start();
    repeat (9) @(negedge clk);
    length = 14'd5;
    pulse_start();
    wait_done("t5", 60);
    check("t5_rises", 32'(rise_data.size()), 32'd2);
    check("t5_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 32'd4);
    check("t5_d1", 32'(rise_data[1]), 32'h3FF);
    check("t5_done_count", 32'(done_cnt), 32'd1);

    // Start and Stop together in OFF
    clear_log();
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    check("t6a_busy", 32'(busy), 32'd0);
    check("t6a_pwrdn", 32'(pwrdn), 32'd1);
    check("t6a_done", 32'(done_cnt), 32'd0);

    // Stop while waking
    clear_log();
    length = 14'd3; div = 16'd3;
    pulse_start();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("t6c_busy", 32'(busy), 32'd0);
    check("t6c_pwrdn", 32'(pwrdn), 32'd1);
    check("t6c_done_pulse", 32'(done), 32'd1);
    repeat (8) @(negedge clk);
    check("t6c_no_reads", 32'(rd_addr.size()), 32'd0);
    check("t6c_done_count", 32'(done_cnt), 32'd1);

    // reset while running
    clear_log();
    length = 14'd1; loop_en = 1'b1; iq = 2'b11;
    pulse_start();
    repeat (20) @(negedge clk);
    check("t1_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_pwrdn", 32'(pwrdn), 32'd1);
    check("t1_sdata", 32'(s_data), 32'h200);
    check("t1_outs", 32'({busy, dclk, open_i, open_q, mem_rd, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_no_done", 32'(done_cnt), 32'd0);
    check("t1_stays_off", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
